// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: forward selects and stall-cause codes.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_LOAD   = 2'b01,
    CAUSE_BRANCH = 2'b10,
    CAUSE_MD     = 2'b11
  } stall_cause_e;

  // Highest-priority cause among the hazards active this cycle.
  function automatic stall_cause_e pick_cause(input logic lw, input logic br, input logic md);
    stall_cause_e c;
    c = CAUSE_NONE;
    if (lw)      c = CAUSE_LOAD;
    else if (br) c = CAUSE_BRANCH;
    else if (md) c = CAUSE_MD;
    return c;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Tracks occupancy of the multi-cycle MULT/DIV unit: busy for MD_LAT cycles after each start.
module md_busy_counter #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MD_LAT);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A start while still busy simply restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (start)              cnt_d = LAT_LOAD;
    else if (cnt_q != '0)   cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS32 core: forwarding selects, load/branch/MULT-DIV stalls,
// a registered stall-cause report and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  rsD,
  input  logic [RA_W-1:0]  rtD,
  input  logic             branchD,
  input  logic             md_useD,
  input  logic [RA_W-1:0]  rsE,
  input  logic [RA_W-1:0]  rtE,
  input  logic             md_startE,
  input  logic             we_regE,
  input  logic             we_regM,
  input  logic             we_regW,
  input  logic [RA_W-1:0]  rf_waE,
  input  logic [RA_W-1:0]  rf_waM,
  input  logic [RA_W-1:0]  rf_waW,
  input  logic             dm_load_opE,
  input  logic             dm_load_opM,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             md_busy,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic lwstall, brstall, mdstall, stall;
  logic brDepE, brDepM;
  stall_cause_e cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  md_busy_counter #(.MD_LAT(MD_LAT)) u_md_busy (
    .clk   (clk),
    .rst   (rst),
    .start (md_startE),
    .busy  (md_busy)
  );

  // Register 0 is hard-wired zero, so a destination of 0 never creates a dependency.
  assign lwstall = dm_load_opE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
  assign brDepE  = we_regE && (rf_waE != '0) && ((rf_waE == rsD) || (rf_waE == rtD));
  assign brDepM  = dm_load_opM && (rf_waM != '0) && ((rf_waM == rsD) || (rf_waM == rtD));
  assign brstall = branchD && (brDepE || brDepM);
  assign mdstall = md_useD && md_busy;
  assign stall   = lwstall || brstall || mdstall;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

  // Branch compare in D can only take a finished ALU result from M, never load data.
  assign forwardAD = (rsD != '0) && we_regM && (rf_waM == rsD) && !dm_load_opM;
  assign forwardBD = (rtD != '0) && we_regM && (rf_waM == rtD) && !dm_load_opM;

  always_comb begin
    forwardAE = FWD_RF;
    if ((rsE != '0) && we_regM && (rf_waM == rsE))      forwardAE = FWD_M;
    else if ((rsE != '0) && we_regW && (rf_waW == rsE)) forwardAE = FWD_W;
  end

  always_comb begin
    forwardBE = FWD_RF;
    if ((rtE != '0) && we_regM && (rf_waM == rtE))      forwardBE = FWD_M;
    else if ((rtE != '0) && we_regW && (rf_waW == rtE)) forwardBE = FWD_W;
  end

  // Cause holds its last value through non-stall cycles; the counter sticks at all-ones.
  always_comb begin
    cause_d = cause_q;
    cnt_d   = cnt_q;
    if (stall) begin
      cause_d = pick_cause(lwstall, brstall, mdstall);
      if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cause = cause_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_scoreboard;

  localparam int RA_W   = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [RA_W-1:0] rsD, rtD, rsE, rtE, rf_waE, rf_waM, rf_waW;
  logic branchD, md_useD, md_startE, we_regE, we_regM, we_regW, dm_load_opE, dm_load_opM;
  logic forwardAD, forwardBD, stallF, stallD, flushE, md_busy;
  logic [1:0] forwardAE, forwardBE, stall_cause;
  logic [CNT_W-1:0] stall_cnt;

  typedef enum int {SG_STALLF, SG_STALLD, SG_FLUSHE, SG_FAD, SG_FBD, SG_FAE, SG_FBE,
                    SG_BUSY, SG_CAUSE, SG_CNT} sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] value;
    int          testId;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int passed = 0;
  int curTest = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.RA_W(RA_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .branchD(branchD), .md_useD(md_useD),
    .rsE(rsE), .rtE(rtE), .md_startE(md_startE),
    .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
    .rf_waE(rf_waE), .rf_waM(rf_waM), .rf_waW(rf_waW),
    .dm_load_opE(dm_load_opE), .dm_load_opM(dm_load_opM),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .md_busy(md_busy), .stall_cause(stall_cause), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] getSig(input sig_e s);
    case (s)
      SG_STALLF: return 32'(stallF);
      SG_STALLD: return 32'(stallD);
      SG_FLUSHE: return 32'(flushE);
      SG_FAD:    return 32'(forwardAD);
      SG_FBD:    return 32'(forwardBD);
      SG_FAE:    return 32'(forwardAE);
      SG_FBE:    return 32'(forwardBE);
      SG_BUSY:   return 32'(md_busy);
      SG_CAUSE:  return 32'(stall_cause);
      default:   return 32'(stall_cnt);
    endcase
  endfunction

  function automatic string sigName(input sig_e s);
    case (s)
      SG_STALLF: return "stallF";
      SG_STALLD: return "stallD";
      SG_FLUSHE: return "flushE";
      SG_FAD:    return "forwardAD";
      SG_FBD:    return "forwardBD";
      SG_FAE:    return "forwardAE";
      SG_FBE:    return "forwardBE";
      SG_BUSY:   return "md_busy";
      SG_CAUSE:  return "stall_cause";
      default:   return "stall_cnt";
    endcase
  endfunction

  // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      logic [31:0] actual;
      e = expQ.pop_front();
      actual = getSig(e.sig);
      checks++;
      if (actual === e.value) passed++;
      else $display("[TB] FAIL t%0d %s: actual=%0h required=%0h",
                    e.testId, sigName(e.sig), actual, e.value);
    end
  end

  task automatic clearInputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    rf_waE = '0; rf_waM = '0; rf_waW = '0;
    branchD = 1'b0; md_useD = 1'b0; md_startE = 1'b0;
    we_regE = 1'b0; we_regM = 1'b0; we_regW = 1'b0;
    dm_load_opE = 1'b0; dm_load_opM = 1'b0;
  endtask

  // Advance one cycle and return to idle inputs just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input sig_e s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.value = v;
    e.testId = curTest;
    expQ.push_back(e);
  endtask

  task automatic checkStall(input logic v);
    checkOutput(SG_STALLF, 32'(v));
    checkOutput(SG_STALLD, 32'(v));
    checkOutput(SG_FLUSHE, 32'(v));
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    clearInputs();

    // Reset state
    curTest = 0;
    applyStimulus();
    checkOutput(SG_BUSY, 0);
    checkOutput(SG_CAUSE, 0);
    checkOutput(SG_CNT, 0);
    checkStall(1'b0);
    checkOutput(SG_FAE, 0);
    rst = 1'b0;

    // Load-use stall
    curTest = 1;
    applyStimulus();
    dm_load_opE = 1'b1; rtE = 5'd8; rsD = 5'd8;
    checkStall(1'b1);
    checkOutput(SG_CAUSE, 0);
    checkOutput(SG_CNT, 0);
    applyStimulus();
    dm_load_opE = 1'b1; rtE = 5'd0; rsD = 5'd0;
    checkStall(1'b0);
    checkOutput(SG_CAUSE, 1);
    checkOutput(SG_CNT, 1);

    // E-stage forwarding, M beats W, register 0 never forwarded
    curTest = 2;
    applyStimulus();
    rsE = 5'd5; rtE = 5'd5; rf_waM = 5'd5; rf_waW = 5'd5; we_regM = 1'b1; we_regW = 1'b1;
    checkOutput(SG_FAE, 2);
    checkOutput(SG_FBE, 2);
    checkStall(1'b0);
    checkOutput(SG_CNT, 1);
    applyStimulus();
    rsE = 5'd5; rf_waM = 5'd5; rf_waW = 5'd5; we_regW = 1'b1;
    checkOutput(SG_FAE, 1);
    checkOutput(SG_FBE, 0);
    applyStimulus();
    we_regM = 1'b1; we_regW = 1'b1;
    checkOutput(SG_FAE, 0);

    // Branch dependent on ALU result in E, then forwarded from M
    curTest = 3;
    applyStimulus();
    branchD = 1'b1; rsD = 5'd3; we_regE = 1'b1; rf_waE = 5'd3;
    checkStall(1'b1);
    checkOutput(SG_FAD, 0);
    applyStimulus();
    branchD = 1'b1; rsD = 5'd3; we_regM = 1'b1; rf_waM = 5'd3;
    checkStall(1'b0);
    checkOutput(SG_FAD, 1);
    checkOutput(SG_CAUSE, 2);
    checkOutput(SG_CNT, 2);

    // Branch dependent on a load in M: stall, no forward
    curTest = 4;
    applyStimulus();
    branchD = 1'b1; rtD = 5'd9; dm_load_opM = 1'b1; we_regM = 1'b1; rf_waM = 5'd9;
    checkStall(1'b1);
    checkOutput(SG_FBD, 0);
    applyStimulus();
    checkOutput(SG_CAUSE, 2);
    checkOutput(SG_CNT, 3);

    // Load and branch together: load wins the cause
    curTest = 7;
    applyStimulus();
    dm_load_opE = 1'b1; rtE = 5'd4; rsD = 5'd4; branchD = 1'b1; we_regE = 1'b1; rf_waE = 5'd4;
    checkStall(1'b1);
    applyStimulus();
    checkOutput(SG_CAUSE, 1);
    checkOutput(SG_CNT, 4);

    // MULT/DIV busy window stalls HI/LO users
    curTest = 5;
    applyStimulus();
    md_startE = 1'b1;
    checkOutput(SG_BUSY, 0);
    checkStall(1'b0);
    for (int i = 0; i < MD_LAT; i++) begin
      applyStimulus();
      md_useD = 1'b1;
      checkOutput(SG_BUSY, 1);
      checkStall(1'b1);
      checkOutput(SG_CNT, 32'(4 + i));
      checkOutput(SG_CAUSE, (i == 0) ? 32'd1 : 32'd3);
    end
    applyStimulus();
    md_useD = 1'b1;
    checkOutput(SG_BUSY, 0);
    checkStall(1'b0);
    checkOutput(SG_CNT, 8);
    checkOutput(SG_CAUSE, 3);

    // Reset in the middle of a MULT/DIV
    curTest = 6;
    applyStimulus();
    md_startE = 1'b1;
    applyStimulus();
    checkOutput(SG_BUSY, 1);
    applyStimulus();
    checkOutput(SG_BUSY, 1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput(SG_BUSY, 0);
    checkOutput(SG_CNT, 0);
    checkOutput(SG_CAUSE, 0);

    // Stall counter saturates at all-ones
    curTest = 8;
    for (int j = 0; j < 19; j++) begin
      applyStimulus();
      dm_load_opE = 1'b1; rtE = 5'd7; rsD = 5'd7;
      checkStall(1'b1);
      checkOutput(SG_CNT, (j > 15) ? 32'd15 : 32'(j));
    end
    applyStimulus();
    checkStall(1'b0);
    checkOutput(SG_CNT, 15);
    checkOutput(SG_CAUSE, 1);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: pending=%0d required=0", expQ.size());
    end
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
